// File: rtl/vga_pkg.sv
// Shared VGA constants for the 800x600@60 pixel pipeline.
// Counter width is shared by the timing generator and the draw chain.
package vga_pkg;

    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;

    localparam int H_FP    = 40;
    localparam int H_SYNC  = 128;
    localparam int H_BP    = 88;
    localparam int H_TOTAL = HOR_PIXELS + H_FP + H_SYNC + H_BP;

    localparam int V_FP    = 1;
    localparam int V_SYNC  = 4;
    localparam int V_BP    = 23;
    localparam int V_TOTAL = VER_PIXELS + V_FP + V_SYNC + V_BP;

    localparam int CNT_W = 11;
    localparam int RGB_W = 12;

endpackage

// File: rtl/vga_if.sv
// Pixel stream bundle passed between draw stages.
// The timing generator drives the head; each stage reads in, drives out.
interface vga_if;
    import vga_pkg::*;

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;

    modport out (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport in (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter with blank/sync strobes decoded
// from the next count so they line up with the count they describe.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = H_TOTAL,
    parameter int ACTIVE     = HOR_PIXELS,
    parameter int SYNC_START = HOR_PIXELS + H_FP,
    parameter int SYNC_LEN   = H_SYNC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_inc,
    input  logic             i_wrap,
    output logic [CNT_W-1:0] o_count,
    output logic             o_blnk,
    output logic             o_sync,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT  = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SS   = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] SE   = CNT_W'(SYNC_START + SYNC_LEN);

    logic [CNT_W-1:0] r_count;
    logic             r_blnk;
    logic             r_sync;
    logic [CNT_W-1:0] w_next;

    // An out-of-range count snaps back to 0 regardless of i_inc.
    always_comb begin
        w_next = r_count;
        if (r_count > LAST) begin
            w_next = '0;
        end else if (i_inc) begin
            w_next = i_wrap ? '0 : r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_blnk  <= 1'b0;
            r_sync  <= 1'b0;
        end else if (i_en) begin
            r_count <= w_next;
            r_blnk  <= (w_next >= ACT);
            r_sync  <= (w_next >= SS) && (w_next < SE);
        end
    end

    assign o_count = r_count;
    assign o_blnk  = r_blnk;
    assign o_sync  = r_sync;
    assign o_tc    = (r_count == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Head of the draw chain: raster counters, sync/blank strobes,
// black background colour and a once-per-frame start pulse.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = HOR_PIXELS,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = VER_PIXELS,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic clk,
    input  logic rst,
    input  logic pix_en,
    vga_if.out   vga_out,
    output logic frame_start
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic             w_h_tc;
    logic             w_v_tc;
    logic [CNT_W-1:0] w_hcount;
    logic [CNT_W-1:0] w_vcount;
    logic             w_hblnk;
    logic             w_hsync;
    logic             w_vblnk;
    logic             w_vsync;
    logic             r_frame_start;

    vga_axis_counter #(
        .TOTAL      (HT),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_LEN   (H_SYNC)
    ) u_h (
        .clk     (clk),
        .rst     (rst),
        .i_en    (pix_en),
        .i_inc   (1'b1),
        .i_wrap  (w_h_tc),
        .o_count (w_hcount),
        .o_blnk  (w_hblnk),
        .o_sync  (w_hsync),
        .o_tc    (w_h_tc)
    );

    vga_axis_counter #(
        .TOTAL      (VT),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_LEN   (V_SYNC)
    ) u_v (
        .clk     (clk),
        .rst     (rst),
        .i_en    (pix_en),
        .i_inc   (w_h_tc),
        .i_wrap  (w_v_tc),
        .o_count (w_vcount),
        .o_blnk  (w_vblnk),
        .o_sync  (w_vsync),
        .o_tc    (w_v_tc)
    );

    // Pulse accompanies the (0,0) reached by wrapping, never the reset one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_start <= 1'b0;
        end else if (pix_en) begin
            r_frame_start <= w_h_tc && w_v_tc;
        end
    end

    assign vga_out.hcount = w_hcount;
    assign vga_out.vcount = w_vcount;
    assign vga_out.hsync  = w_hsync;
    assign vga_out.vsync  = w_vsync;
    assign vga_out.hblnk  = w_hblnk;
    assign vga_out.vblnk  = w_vblnk;
    assign vga_out.rgb    = '0;
    assign frame_start    = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full 800-wide line timing with a
// shortened vertical (4 active, 1 fp, 2 sync, 2 bp = 9 lines/frame).
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int HTOT  = 1056;
    localparam int VTOT  = 9;
    localparam int FRAME = HTOT * VTOT;

    logic clk;
    logic rst;
    logic pix_en;
    logic frame_start;

    int n_tests;
    int n_fail;

    vga_if vif ();

    vga_timing_gen #(
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .vga_out     (vif),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] strobes();
        return {vif.hsync, vif.vsync, vif.hblnk, vif.vblnk};
    endfunction

    initial begin
        int hs_cnt;
        int vs_cnt;
        int fs_cnt;
        int rise_h;
        int rise_v;
        int max_h;
        int max_v;
        int rgb_bad;
        int t_fs[3];
        logic prev_vblnk;

        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        pix_en  = 1'b1;

        // Reset state
        step(2);
        chk("rst_hcount", 32'(vif.hcount), 0);
        chk("rst_vcount", 32'(vif.vcount), 0);
        chk("rst_strobes", 32'(strobes()), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_rgb", 32'(vif.rgb), 0);

        // First enabled edge
        rst = 1'b0;
        step(1);
        chk("first_hcount", 32'(vif.hcount), 1);
        chk("first_vcount", 32'(vif.vcount), 0);
        chk("first_strobes", 32'(strobes()), 0);
        chk("first_fs", 32'(frame_start), 0);

        // Active/blank boundary
        step(798);
        chk("h799", 32'(vif.hcount), 799);
        chk("h799_hblnk", 32'(vif.hblnk), 0);
        step(1);
        chk("h800", 32'(vif.hcount), 800);
        chk("h800_hblnk", 32'(vif.hblnk), 1);
        chk("h800_hsync", 32'(vif.hsync), 0);

        // Freeze at 839 for 7 cycles
        step(39);
        chk("h839", 32'(vif.hcount), 839);
        chk("h839_hsync", 32'(vif.hsync), 0);
        pix_en = 1'b0;
        step(7);
        chk("frz_hcount", 32'(vif.hcount), 839);
        chk("frz_hsync", 32'(vif.hsync), 0);
        chk("frz_hblnk", 32'(vif.hblnk), 1);
        pix_en = 1'b1;
        step(1);
        chk("h840", 32'(vif.hcount), 840);
        chk("h840_hsync", 32'(vif.hsync), 1);

        // hsync width across the rest of the line
        hs_cnt = 1;
        for (int i = 841; i <= 1055; i++) begin
            step(1);
            if (vif.hsync) hs_cnt++;
        end
        chk("h1055", 32'(vif.hcount), 1055);
        chk("hsync_len", 32'(hs_cnt), 128);
        step(1);
        chk("hwrap_h", 32'(vif.hcount), 0);
        chk("hwrap_v", 32'(vif.vcount), 1);
        chk("hwrap_hblnk", 32'(vif.hblnk), 0);
        chk("hwrap_fs", 32'(frame_start), 0);

        // Remainder of the frame from (0,1) to (0,0)
        vs_cnt     = 0;
        fs_cnt     = 0;
        rise_h     = -1;
        rise_v     = -1;
        prev_vblnk = vif.vblnk;
        for (int i = 1; i <= FRAME - HTOT; i++) begin
            if (i == FRAME - HTOT) begin
                chk("last_h", 32'(vif.hcount), 1055);
                chk("last_v", 32'(vif.vcount), 8);
                chk("last_strobes", 32'(strobes()), 32'b0011);
            end
            step(1);
            if (vif.vsync) vs_cnt++;
            if (frame_start) fs_cnt++;
            if (vif.vblnk && !prev_vblnk && rise_h < 0) begin
                rise_h = 32'(vif.hcount);
                rise_v = 32'(vif.vcount);
            end
            prev_vblnk = vif.vblnk;
        end
        chk("vblnk_rise_h", 32'(rise_h), 0);
        chk("vblnk_rise_v", 32'(rise_v), 4);
        chk("vsync_cycles", 32'(vs_cnt), 2 * HTOT);
        chk("fs_count", 32'(fs_cnt), 1);
        chk("wrap_h", 32'(vif.hcount), 0);
        chk("wrap_v", 32'(vif.vcount), 0);
        chk("wrap_strobes", 32'(strobes()), 0);
        chk("wrap_fs", 32'(frame_start), 1);

        // frame_start stretches while disabled
        pix_en = 1'b0;
        step(2);
        chk("fs_hold", 32'(frame_start), 1);
        chk("fs_hold_h", 32'(vif.hcount), 0);
        pix_en = 1'b1;
        step(1);
        chk("fs_drop", 32'(frame_start), 0);
        chk("fs_drop_h", 32'(vif.hcount), 1);

        // Reset mid-frame inside both sync pulses
        step(5 * HTOT + 899);
        chk("pre_rst_h", 32'(vif.hcount), 900);
        chk("pre_rst_v", 32'(vif.vcount), 5);
        chk("pre_rst_sync", 32'({vif.hsync, vif.vsync}), 3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_rst_h", 32'(vif.hcount), 0);
        chk("mid_rst_v", 32'(vif.vcount), 0);
        chk("mid_rst_strobes", 32'(strobes()), 0);
        chk("mid_rst_fs", 32'(frame_start), 0);
        step(1);
        chk("resume_h", 32'(vif.hcount), 1);
        chk("resume_v", 32'(vif.vcount), 0);

        // Three frames: pulse period, bounds, rgb
        fs_cnt  = 0;
        max_h   = 0;
        max_v   = 0;
        rgb_bad = 0;
        for (int i = 1; i <= 3 * FRAME; i++) begin
            step(1);
            if (frame_start) begin
                if (fs_cnt < 3) t_fs[fs_cnt] = i;
                fs_cnt++;
            end
            if (32'(vif.hcount) > max_h) max_h = 32'(vif.hcount);
            if (32'(vif.vcount) > max_v) max_v = 32'(vif.vcount);
            if (vif.rgb !== 12'h000) rgb_bad++;
        end
        chk("long_fs_count", 32'(fs_cnt), 3);
        if (fs_cnt == 3) begin
            chk("fs_first", 32'(t_fs[0]), FRAME - 1);
            chk("fs_period1", 32'(t_fs[1] - t_fs[0]), FRAME);
            chk("fs_period2", 32'(t_fs[2] - t_fs[1]), FRAME);
        end
        chk("max_hcount", 32'(max_h), 1055);
        chk("max_vcount", 32'(max_v), VTOT - 1);
        chk("rgb_black", 32'(rgb_bad), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
